// File: rtl/input_event_queue_if.sv
// CPU-side read port of the button event queue.
// Port summary: cpu_read_en (pop request), data_to_cpu (show-ahead head word),
//   fifo_empty / fifo_full / fifo_count (occupancy), overflow (sticky drop flag).
interface input_event_queue_if #(
  parameter int FIFO_DEPTH = 8
) ();
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             cpu_read_en;
  logic [15:0]      data_to_cpu;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;

  // CPU side
  modport master (
    output cpu_read_en,
    input  data_to_cpu, fifo_empty, fifo_full, fifo_count, overflow
  );

  // Queue side
  modport slave (
    input  cpu_read_en,
    output data_to_cpu, fifo_empty, fifo_full, fifo_count, overflow
  );
endinterface

// File: rtl/input_event_queue.sv
// Debounced button event queue: sync -> debounce -> edge detect -> event FIFO.
// Latency: raw change to queued word is 2 sync + DEBOUNCE_CYCLES + 1 edge cycles.
// Backpressure: none upstream; a push into a full queue without a pop is
//   dropped and sets the sticky overflow flag.
// Ports: sys_clock, reset (sync, active low), buttons_in[NUM_BTN] (raw levels),
//   cpu (input_event_queue_if.slave read port).
module input_event_queue #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FIFO_DEPTH      = 8,
  parameter int EDGE_MODE       = 0
) (
  input  logic               sys_clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] buttons_in,
  input_event_queue_if.slave cpu
);

  localparam int DCW   = $clog2(DEBOUNCE_CYCLES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // ---------------------------------------------------------------
  // Synchroniser and debounce
  // ---------------------------------------------------------------
  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] r_deb;
  logic [NUM_BTN-1:0] r_deb_q;
  logic [DCW-1:0]     r_cnt [NUM_BTN];

  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= buttons_in;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          // The edge on which the counter already holds D-1 is the D-th
          // consecutive differing cycle: accept the new level.
          if (r_cnt[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
            r_deb[i] <= ~r_deb[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Edge detect and event word (one word per cycle, however many bits moved)
  // ---------------------------------------------------------------
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_release;
  logic [11:0]        w_press_ext;
  logic [11:0]        w_deb_ext;
  logic               w_evt_vld;
  logic [15:0]        w_evt_dat;

  assign w_press   = r_deb & ~r_deb_q;
  assign w_release = ~r_deb & r_deb_q;

  always_comb begin
    w_press_ext = '0;
    w_deb_ext   = '0;
    w_press_ext[NUM_BTN-1:0] = w_press;
    w_deb_ext[NUM_BTN-1:0]   = r_deb;
    w_evt_vld = 1'b0;
    w_evt_dat = 16'h0000;
    if (EDGE_MODE == 0) begin
      w_evt_vld = (w_press != '0);
      w_evt_dat = {1'b1, 1'b0, 2'b00, w_press_ext};
    end else begin
      w_evt_vld = (w_press != '0) || (w_release != '0);
      w_evt_dat = {1'b1, (w_release != '0), 2'b00, w_deb_ext};
    end
  end

  // ---------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------
  logic [15:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop   = cpu.cpu_read_en && !w_empty;
  // A simultaneous pop frees the slot, so a full queue still accepts the push.
  assign w_push  = w_evt_vld && (!w_full || w_pop);
  assign w_drop  = w_evt_vld && w_full && !w_pop;

  always_ff @(posedge sys_clock) begin
    if (reset && w_push) begin
      r_mem[r_wr_ptr] <= w_evt_dat;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      // Pointers are power-of-two wide, so they wrap modulo FIFO_DEPTH.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_pop) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign cpu.data_to_cpu = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
  assign cpu.fifo_empty  = w_empty;
  assign cpu.fifo_full   = w_full;
  assign cpu.fifo_count  = r_count;
  assign cpu.overflow    = r_ovf;

endmodule

// File: doc/input_event_queue.md
INPUT_EVENT_QUEUE -- requirements
Module: input_event_queue

Interface
REQ-001 Parameter NUM_BTN, default 4, number of button inputs; legal range 1..12.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000, consecutive stable cycles required to accept a level change; legal range >=2.
REQ-003 Parameter FIFO_DEPTH, default 8, event queue depth; power of two, 2..64.
REQ-004 Parameter EDGE_MODE, default 0; 0 = queue press events only, 1 = queue press and release events.
REQ-005 sys_clock  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (reset==0 resets on the clock edge).
REQ-007 buttons_in  input  NUM_BTN  raw asynchronous button levels, 1 = pressed.
REQ-008 cpu_read_en  input  1  pop request, one pop per asserted cycle.
REQ-009 data_to_cpu  output  16  head-of-queue event word, show-ahead.
REQ-010 fifo_empty  output  1  queue holds no events.
REQ-011 fifo_full  output  1  queue holds FIFO_DEPTH events.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH+1)  number of queued events.
REQ-013 overflow  output  1  sticky flag: at least one event dropped.

Function
REQ-014 Each buttons_in bit SHALL pass through a two-flop synchroniser before any other use.
REQ-015 Per button, a debounce counter SHALL increment each cycle the synchronised level differs from the debounced level, and clear to 0 whenever they are equal.
REQ-016 When a counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level SHALL toggle on that edge and the counter SHALL clear.
REQ-017 Input change captured at edge t SHALL appear on the debounced level at edge t+2+DEBOUNCE_CYCLES-1 if stable throughout; any glitch resets the count.
REQ-018 Per cycle: press_mask = debounced rising bits, release_mask = debounced falling bits, computed from the one-cycle-registered debounced vector.
REQ-019 EDGE_MODE=0: one event SHALL be generated in a cycle with press_mask!=0; word = {1'b1, 1'b0, 2'b00, zero-extended press_mask to 12 bits}.
REQ-020 EDGE_MODE=1: a cycle with press_mask!=0 or release_mask!=0 SHALL generate exactly one event; word = {1'b1, (release_mask!=0), 2'b00, zero-extended full debounced vector}.
REQ-021 Simultaneous changes on several buttons in one cycle SHALL produce a single event, never several.
REQ-022 Event generated at edge e SHALL be written into the queue at edge e+1; fifo_empty falls and fifo_count increments at that edge.
REQ-023 data_to_cpu SHALL combinationally present the head entry when not empty, and 16'h0000 when empty (bit 15 = valid).
REQ-024 cpu_read_en while not empty SHALL remove the head at the edge; the next entry is visible the following cycle.
REQ-025 cpu_read_en while empty SHALL be ignored: no pointer, count or flag change.
REQ-026 Push and pop in the same cycle SHALL both occur, count unchanged, including when full; no overflow in that case.
REQ-027 Push while full without pop SHALL drop the new event, keep queue contents, and set overflow.
REQ-028 overflow SHALL clear on the next successful pop after it was set, unless a drop occurs in that same cycle.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_full = (fifo_count==FIFO_DEPTH).

Reset
REQ-030 While reset==0 at an edge: queue emptied, pointers 0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0, data_to_cpu=16'h0000.
REQ-031 Reset SHALL clear synchronisers, debounced levels (all 0) and counters; a button held through reset is reported as a press once stable DEBOUNCE_CYCLES after release of reset.
REQ-032 Reset asserted mid-debounce or with a pending push SHALL discard that event.

Verification (NUM_BTN=4, DEBOUNCE_CYCLES=4, FIFO_DEPTH=4 unless stated)
REQ-033 buttons_in 0000->0010 held 10 cycles, EDGE_MODE=0 -> exactly one event 16'h8002, fifo_count=1 at edge t+6.
REQ-034 Bit0 pulses high 2 cycles then low -> no event, counter returns to 0, fifo_empty stays 1.
REQ-035 EDGE_MODE=1, bits 0 and 3 pressed same cycle then both released -> events 16'h8009 then 16'h4000|16'h8000=16'hC000.
REQ-036 Five presses without reads -> fifo_full=1, fifo_count=4, overflow=1, first four words retained; one pop -> overflow=0, count=3.
REQ-037 Queue full, event push coincident with cpu_read_en -> count stays 4, overflow stays 0, new event at tail.
REQ-038 cpu_read_en held while empty for 5 cycles -> data_to_cpu=16'h0000, count 0, no pointer movement; reset==0 mid-queue -> all outputs to REQ-030 values next edge.
